// File: rtl/sna_flit_boxer_pkg.sv
// Flit definitions shared by the response-side boxer and the request-side
// unboxer: flit type codes, field bit positions, FSM state type and flit
// builders.
package sna_flit_boxer_pkg;

  localparam int FLIT_W = 37;

  // Flit type codes carried in the top two bits of every flit
  localparam logic [1:0] FLIT_HDR  = 2'b10;
  localparam logic [1:0] FLIT_ADDR = 2'b00;
  localparam logic [1:0] FLIT_DATA = 2'b01;

  // Field bit positions
  localparam int TYPE_HI = 36;
  localparam int TYPE_LO = 35;
  localparam int SRC_HI  = 31;
  localparam int SRC_LO  = 28;
  localparam int DEST_HI = 27;
  localparam int DEST_LO = 24;
  localparam int RESP_HI = 2;
  localparam int RESP_LO = 1;
  localparam int READ_BIT = 0;
  localparam int PAYLOAD_HI = 31;
  localparam int PAYLOAD_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } box_state_e;

  // Header flit: type, source, destination, response code and read flag
  function automatic logic [FLIT_W-1:0] make_header(
    input logic [3:0] src,
    input logic [3:0] dest,
    input logic [1:0] resp,
    input logic       read
  );
    logic [FLIT_W-1:0] flit;
    flit                   = '0;
    flit[TYPE_HI:TYPE_LO]  = FLIT_HDR;
    flit[SRC_HI:SRC_LO]    = src;
    flit[DEST_HI:DEST_LO]  = dest;
    flit[RESP_HI:RESP_LO]  = resp;
    flit[READ_BIT]         = read;
    return flit;
  endfunction

  // Body flit: read data for reads, the zero-extended response code for writes
  function automatic logic [FLIT_W-1:0] make_body(
    input logic        read,
    input logic [31:0] data,
    input logic [1:0]  resp
  );
    logic [FLIT_W-1:0] flit;
    flit                        = '0;
    flit[TYPE_HI:TYPE_LO]       = FLIT_DATA;
    flit[PAYLOAD_HI:PAYLOAD_LO] = read ? data : {30'b0, resp};
    return flit;
  endfunction

endpackage

// File: rtl/sna_flit_boxer.sv
// Response boxer: takes one AXI-side response, holds it, and emits it to the
// NoC as a two-flit packet (header then body) with full backpressure support.
module sna_flit_boxer
  import sna_flit_boxer_pkg::*;
#(
  parameter logic [3:0] SRC_ID = 4'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rsp_valid,
  output logic              rsp_ready,
  input  logic              rsp_read,
  input  logic [31:0]       rsp_data,
  input  logic [1:0]        rsp_resp,
  input  logic [3:0]        rsp_dest,
  output logic [FLIT_W-1:0] noc_data,
  output logic              noc_valid,
  input  logic              noc_ready,
  output logic              busy
);

  box_state_e state_reg, state_next;

  logic        hold_read_reg, hold_read_next;
  logic [31:0] hold_data_reg, hold_data_next;
  logic [1:0]  hold_resp_reg, hold_resp_next;
  logic [3:0]  hold_dest_reg, hold_dest_next;

  logic              rsp_ready_next;
  logic              noc_valid_next;
  logic [FLIT_W-1:0] noc_data_next;
  logic              accept;

  // A response is taken only when the registered ready is up, which is never
  // the case outside IDLE, so inputs are ignored while a packet is in flight.
  assign accept = rsp_valid & rsp_ready;
  assign busy   = (state_reg != ST_IDLE);

  // Next-state and holding-register capture
  always_comb begin
    state_next     = state_reg;
    hold_read_next = hold_read_reg;
    hold_data_next = hold_data_reg;
    hold_resp_next = hold_resp_reg;
    hold_dest_next = hold_dest_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next     = ST_HEAD;
          hold_read_next = rsp_read;
          hold_data_next = rsp_data;
          hold_resp_next = rsp_resp;
          hold_dest_next = rsp_dest;
        end
      end
      ST_HEAD: if (noc_ready) state_next = ST_BODY;
      ST_BODY: if (noc_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output values are derived from the state being entered, so the flit is
  // registered and appears in the same cycle as the state it belongs to.
  always_comb begin
    rsp_ready_next = (state_next == ST_IDLE);
    noc_valid_next = (state_next != ST_IDLE);
    noc_data_next  = '0;
    unique case (state_next)
      ST_HEAD: noc_data_next = make_header(SRC_ID, hold_dest_next, hold_resp_next, hold_read_next);
      ST_BODY: noc_data_next = make_body(hold_read_next, hold_data_next, hold_resp_next);
      default: noc_data_next = '0;
    endcase
  end

  // State and holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      hold_read_reg <= 1'b0;
      hold_data_reg <= '0;
      hold_resp_reg <= '0;
      hold_dest_reg <= '0;
    end else begin
      state_reg     <= state_next;
      hold_read_reg <= hold_read_next;
      hold_data_reg <= hold_data_next;
      hold_resp_reg <= hold_resp_next;
      hold_dest_reg <= hold_dest_next;
    end
  end

  // Output registers; ready stays low during reset and rises on the first edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_ready <= 1'b0;
      noc_valid <= 1'b0;
      noc_data  <= '0;
    end else begin
      rsp_ready <= rsp_ready_next;
      noc_valid <= noc_valid_next;
      noc_data  <= noc_data_next;
    end
  end

endmodule
